// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel receive path.
package pixel_pkg;

    localparam int unsigned IMG_W     = 1024;
    localparam int unsigned IMG_H     = 1024;
    localparam int unsigned H_MINUS_1 = IMG_H - 1;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned PIX_W     = 8;

    // One buffered pixel with its raster position tags.
    typedef struct packed {
        logic             eof;
        logic             eol;
        logic             sol;
        logic [PIX_W-1:0] data;
    } tagged_pix_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOL,
        CAPTURE,
        DRAIN,
        DONE
    } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// The output register always holds the oldest entry, so the first word
// appears one cycle after it is written into an empty FIFO.
module sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    remain;
    logic [WIDTH-1:0] data_q, data_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    // Push/pop qualification, pointer/count update and next head value.
    always_comb begin
        full     = (count_q == CNT_FULL);
        pop      = rd_en & ~empty_q;
        push     = wr_en & (~full | pop);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        remain   = count_q - CW'(pop);
        empty_d  = (count_d == '0);
        // When nothing older survives the pop, the incoming word becomes the
        // head directly; otherwise the next head is already in the array.
        if (remain == '0) begin
            data_d = push ? wr_data : data_q;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = data_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/pixel_rx_sink.sv
// Capture of a free-running raster pixel stream: geometry check, SOL/EOL/EOF
// tagging and buffering onto a valid/ready output stream.
module pixel_rx_sink #(
    parameter int unsigned IMG_W      = pixel_pkg::IMG_W,
    parameter int unsigned IMG_H      = pixel_pkg::IMG_H,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_en,
    input  logic [7:0] pix_in,
    input  logic       sol_in,
    input  logic       done_in,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sol,
    output logic       m_eol,
    output logic       m_eof,
    output logic [9:0] line_cnt,
    output logic       overflow,
    output logic       len_err,
    output logic       frame_ok
);

    import pixel_pkg::*;

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    // A 1024-line frame does not fit the 10-bit counter; clamp to its maximum.
    localparam int unsigned LINE_SAT = (IMG_H < (1 << COORD_W)) ? IMG_H : (1 << COORD_W) - 1;
    localparam logic [COORD_W-1:0] LINE_MAX = COORD_W'(LINE_SAT);

    cap_state_t         state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COORD_W-1:0] line_cnt_q, line_cnt_d;
    logic               overflow_q, overflow_d;
    logic               len_err_q, len_err_d;
    logic               frame_ok_q, frame_ok_d;

    logic               capture;
    logic               tag_sol, tag_eol, tag_eof;
    logic               pop;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    tagged_pix_t        wr_pix, rd_pix;

    // Next-state, raster counters, tagging and geometry/overflow flags.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        line_cnt_d = line_cnt_q;
        overflow_d = overflow_q;
        len_err_d  = len_err_q;
        frame_ok_d = frame_ok_q;
        capture    = 1'b0;

        pop     = ~fifo_empty & m_ready;
        tag_sol = (col_q == '0);
        tag_eol = (col_q == COL_LAST);
        tag_eof = tag_eol & (row_q == ROW_LAST);

        wr_pix.eof  = tag_eof;
        wr_pix.eol  = tag_eol;
        wr_pix.sol  = tag_sol;
        wr_pix.data = pix_in;

        case (state_q)
            IDLE, DONE: begin
                if (cap_en) begin
                    state_d    = WAIT_SOL;
                    col_d      = '0;
                    row_d      = '0;
                    line_cnt_d = '0;
                    overflow_d = 1'b0;
                    len_err_d  = 1'b0;
                    frame_ok_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_SOL: begin
                capture = sol_in;
            end
            CAPTURE: begin
                capture = 1'b1;
            end
            DRAIN: begin
                if (fifo_count == '0) begin
                    state_d    = DONE;
                    frame_ok_d = ~overflow_q & ~len_err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            if (sol_in != tag_sol) begin
                len_err_d = 1'b1;
            end
            if (done_in != tag_eof) begin
                len_err_d = 1'b1;
            end
            if (fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
            if (tag_eol) begin
                col_d = '0;
                row_d = tag_eof ? '0 : row_q + ROW_W'(1);
                if (line_cnt_q != LINE_MAX) begin
                    line_cnt_d = line_cnt_q + COORD_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
            state_d = tag_eof ? DRAIN : CAPTURE;
        end
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            line_cnt_q <= '0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
            frame_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            line_cnt_q <= line_cnt_d;
            overflow_q <= overflow_d;
            len_err_q  <= len_err_d;
            frame_ok_q <= frame_ok_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(tagged_pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (wr_pix),
        .rd_en   (m_ready),
        .rd_data (rd_pix),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_data   = rd_pix.data;
    assign m_sol    = rd_pix.sol;
    assign m_eol    = rd_pix.eol;
    assign m_eof    = rd_pix.eof;
    assign m_valid  = ~fifo_empty;
    assign line_cnt = line_cnt_q;
    assign overflow = overflow_q;
    assign len_err  = len_err_q;
    assign frame_ok = frame_ok_q;

endmodule

// File: tb/tb_pixel_rx_sink.sv
// Directed bench for pixel_rx_sink with a scoreboard on the output stream.
module tb_pixel_rx_sink;

    import pixel_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst, cap_en, sol_in, done_in, m_ready;
    logic [7:0] pix_in;
    logic [7:0] m_data;
    logic       m_valid, m_sol, m_eol, m_eof;
    logic [9:0] line_cnt;
    logic       overflow, len_err, frame_ok;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    pixel_rx_sink #(
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .pix_in   (pix_in),
        .sol_in   (sol_in),
        .done_in  (done_in),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sol    (m_sol),
        .m_eol    (m_eol),
        .m_eof    (m_eof),
        .line_cnt (line_cnt),
        .overflow (overflow),
        .len_err  (len_err),
        .frame_ok (frame_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pix_in  = 8'h00;
        sol_in  = 1'b0;
        done_in = 1'b0;
    endtask

    // Drive one raster pixel; idx is its position in the frame, keep says
    // whether it is expected to reach the output.
    task automatic send(input logic [7:0] p, input logic s, input logic d,
                        input int unsigned idx, input bit keep);
        pix_in  = p;
        sol_in  = s;
        done_in = d;
        if (keep) begin
            sb.push_back({(idx == W*H-1), (idx % W == W-1), (idx % W == 0), p});
        end
        step();
    endtask

    task automatic arm();
        cap_en = 1'b1;
        step();
        cap_en = 1'b0;
    endtask

    task automatic wait_state(input cap_state_t s, input int max_cycles);
        int n = 0;
        while (dut.state_q != s && n < max_cycles) begin
            step();
            n++;
        end
        check("wait_state", 32'(dut.state_q), 32'(s));
    endtask

    // Output scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("out_unexpected", {m_eof, m_eol, m_sol, m_data}, 32'hFFF);
            end else begin
                check("out_beat", {m_eof, m_eol, m_sol, m_data}, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cap_en = 1'b0; m_ready = 1'b0;
        idle_in();
        step();
        step();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_tags", {m_sol, m_eol, m_eof}, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_flags", {overflow, len_err, frame_ok}, 0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;

        // Arming: stream activity in IDLE and WAIT_SOL must not be captured.
        m_ready = 1'b1;
        pix_in = 8'hAA; sol_in = 1'b1; done_in = 1'b1;
        step();
        step();
        check("idle_no_push", m_valid, 0);
        check("idle_state", 32'(dut.state_q), 32'(IDLE));
        arm();
        check("armed_state", 32'(dut.state_q), 32'(WAIT_SOL));
        pix_in = 8'hBB; sol_in = 1'b0; done_in = 1'b0;
        step();
        step();
        check("wait_no_push", m_valid, 0);
        check("wait_state_held", 32'(dut.state_q), 32'(WAIT_SOL));

        // Nominal frame starting at the first sol_in in WAIT_SOL.
        for (int i = 0; i < 8; i++) begin
            send(8'(i), (i % W == 0), (i == 7), i, 1'b1);
            if (i == 3) check("nom_line_cnt_1", line_cnt, 1);
        end
        idle_in();
        wait_state(DONE, 20);
        check("nom_frame_ok", frame_ok, 1);
        check("nom_line_cnt", line_cnt, 2);
        check("nom_flags", {overflow, len_err}, 0);
        check("nom_sb_empty", sb.size(), 0);
        step();
        check("done_to_idle", 32'(dut.state_q), 32'(IDLE));
        check("idle_frame_ok_kept", frame_ok, 1);

        // Backpressure: only the first D pixels fit, the rest are dropped.
        m_ready = 1'b0;
        arm();
        check("bp_frame_ok_cleared", frame_ok, 0);
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), (i % W == 0), (i == 7), i, (i < D));
            if (i == 3) check("bp_no_ovf_yet", overflow, 0);
            if (i == 4) check("bp_ovf_set", overflow, 1);
        end
        idle_in();
        check("bp_hold_valid", m_valid, 1);
        check("bp_hold_data", m_data, 8'h10);
        check("bp_drain_state", 32'(dut.state_q), 32'(DRAIN));
        m_ready = 1'b1;
        wait_state(DONE, 20);
        check("bp_frame_ok", frame_ok, 0);
        check("bp_overflow", overflow, 1);
        check("bp_sb_empty", sb.size(), 0);

        // Full FIFO with simultaneous push and pop.
        m_ready = 1'b0;
        arm();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) m_ready = 1'b1;
            send(8'h20 + 8'(i), (i % W == 0), (i == 7), i, 1'b1);
            if (i == 3) check("pp_full_count", dut.u_fifo.count, D);
            if (i == 4) begin
                check("pp_count_kept", dut.u_fifo.count, D);
                check("pp_no_ovf", overflow, 0);
            end
        end
        idle_in();
        wait_state(DONE, 20);
        check("pp_frame_ok", frame_ok, 1);
        check("pp_overflow", overflow, 0);
        check("pp_sb_empty", sb.size(), 0);

        // Geometry: early sol_in at col 2 and stray done_in on pixel 5.
        arm();
        for (int i = 0; i < 8; i++) begin
            send(8'h30 + 8'(i), (i % W == 0) || (i == 2), (i == 5) || (i == 7), i, 1'b1);
            if (i == 1) check("geo_no_err_yet", len_err, 0);
            if (i == 2) check("geo_err_set", len_err, 1);
            if (i == 6) check("geo_still_capture", 32'(dut.state_q), 32'(CAPTURE));
            if (i == 7) check("geo_ends_on_eof", 32'(dut.state_q), 32'(DRAIN));
        end
        idle_in();
        wait_state(DONE, 20);
        check("geo_frame_ok", frame_ok, 0);
        check("geo_line_cnt", line_cnt, 2);
        check("geo_sb_empty", sb.size(), 0);

        // Reset mid-frame with two entries buffered.
        m_ready = 1'b0;
        arm();
        send(8'h40, 1'b1, 1'b0, 0, 1'b1);
        m_ready = 1'b1;
        send(8'h41, 1'b1, 1'b0, 1, 1'b1);
        m_ready = 1'b0;
        send(8'h42, 1'b0, 1'b0, 2, 1'b1);
        idle_in();
        check("mid_count", dut.u_fifo.count, 2);
        check("mid_len_err", len_err, 1);
        rst = 1'b1;
        sb.delete();
        step();
        check("mr_m_valid", m_valid, 0);
        check("mr_line_cnt", line_cnt, 0);
        check("mr_flags", {overflow, len_err, frame_ok}, 0);
        check("mr_state", 32'(dut.state_q), 32'(IDLE));
        check("mr_count", dut.u_fifo.count, 0);
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
